// File: rtl/motor_cmd_scheduler.sv
// Parses 7-byte UART command frames, slew-limits four sign-magnitude motor outputs,
// drives brake/kick flags and falls back to a safe stop when good frames stop arriving.
module motor_cmd_scheduler #(
    parameter logic [7:0]  HEADER   = 8'hFF,
    parameter int unsigned BYTE_TO  = 50000,
    parameter int unsigned WDOG     = 5000000,
    parameter int unsigned RAMP_DIV = 50000,
    parameter int unsigned STEP     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] serial,
    input  logic       received,
    output logic [7:0] motor1,
    output logic [7:0] motor2,
    output logic [7:0] motor3,
    output logic [7:0] motor4,
    output logic       brake1,
    output logic       brake2,
    output logic       brake3,
    output logic       brake4,
    output logic [7:0] kicker,
    output logic       kickb,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       wdog_expired
);

    localparam int unsigned BW = $clog2(BYTE_TO + 1);
    localparam int unsigned WW = $clog2(WDOG + 1);
    localparam int unsigned RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [6:0]  STEP_MAG = 7'(STEP);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

    state_t           state, state_d;
    logic [2:0]       idx, idx_d;
    logic [7:0]       csum, csum_d;
    logic [4:0][7:0]  shadow;
    logic [BW-1:0]    byte_cnt;
    logic [RW-1:0]    ramp_cnt;
    logic [WW-1:0]    wdog_cnt;
    logic [3:0][7:0]  tgt, mot, mot_d;
    logic [3:0]       brake;
    logic [7:0]       kicker_d;
    logic             store_c, commit_c, err_c, timeout_c, tick_c, expire_c;

    // Move one motor output a single ramp step toward its target
    function automatic logic [7:0] ramp_step(input logic [7:0] cur, input logic [7:0] tg);
        logic [6:0] cm, tm, diff, nm;
        logic       dir;
        cm = cur[6:0];
        tm = tg[6:0];
        if (cm == 7'd0 || cur[7] == tg[7]) begin
            dir = tg[7];
            if (tm >= cm) begin
                diff = tm - cm;
                nm   = cm + ((diff > STEP_MAG) ? STEP_MAG : diff);
            end else begin
                diff = cm - tm;
                nm   = cm - ((diff > STEP_MAG) ? STEP_MAG : diff);
            end
        end else begin
            dir = cur[7];
            nm  = cm - ((cm > STEP_MAG) ? STEP_MAG : cm);
        end
        return (nm == 7'd0) ? 8'h00 : {dir, nm};
    endfunction

    assign timeout_c = (state != IDLE) && !received && (byte_cnt == BW'(BYTE_TO - 1));
    assign tick_c    = (ramp_cnt == RW'(RAMP_DIV - 1));
    assign expire_c  = !wdog_expired && !commit_c && (wdog_cnt == WW'(WDOG - 1));

    // Frame parser next-state logic
    always_comb begin
        state_d  = state;
        idx_d    = idx;
        csum_d   = csum;
        store_c  = 1'b0;
        commit_c = 1'b0;
        err_c    = 1'b0;
        case (state)
            IDLE: begin
                if (received && serial == HEADER) begin
                    state_d = PAYLOAD;
                    idx_d   = 3'd0;
                    csum_d  = 8'h00;
                end
            end
            PAYLOAD: begin
                if (received) begin
                    store_c = 1'b1;
                    csum_d  = csum ^ serial;
                    if (idx == 3'd4) state_d = CHECK;
                    else             idx_d   = idx + 3'd1;
                end else if (timeout_c) begin
                    err_c   = 1'b1;
                    state_d = IDLE;
                end
            end
            CHECK: begin
                if (received) begin
                    if (serial == csum) commit_c = 1'b1;
                    else                err_c    = 1'b1;
                    state_d = IDLE;
                end else if (timeout_c) begin
                    err_c   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 3'd0;
            csum  <= 8'h00;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            csum  <= csum_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store_c) shadow[idx] <= serial;
    end

    // Byte-gap, ramp-tick and watchdog counters
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || received) byte_cnt <= '0;
        else                                  byte_cnt <= byte_cnt + BW'(1);

        if (rst || tick_c) ramp_cnt <= '0;
        else               ramp_cnt <= ramp_cnt + RW'(1);

        if (rst || commit_c) begin
            wdog_cnt     <= '0;
            wdog_expired <= 1'b0;
        end else if (expire_c) begin
            wdog_cnt     <= WW'(WDOG);
            wdog_expired <= 1'b1;
        end else if (!wdog_expired) begin
            wdog_cnt     <= wdog_cnt + WW'(1);
        end
    end

    // Next output values; a tick always ramps toward the targets held before this edge
    always_comb begin
        kicker_d = kicker;
        mot_d    = mot;
        for (int i = 0; i < 4; i++) begin
            if (tick_c) mot_d[i] = ramp_step(mot[i], tgt[i]);
        end
        if (commit_c)      kicker_d = shadow[4];
        else if (expire_c) kicker_d = 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mot       <= '0;
            tgt       <= '0;
            brake     <= 4'hF;
            kicker    <= 8'h00;
            kickb     <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            mot       <= mot_d;
            for (int i = 0; i < 4; i++) brake[i] <= (mot_d[i][6:0] == 7'd0);
            kicker    <= kicker_d;
            kickb     <= (kicker_d[6:0] != 7'd0);
            frame_ok  <= commit_c;
            frame_err <= err_c;
            if (commit_c)      tgt <= shadow[3:0];
            else if (expire_c) tgt <= '0;
        end
    end

    assign motor1 = mot[0];
    assign motor2 = mot[1];
    assign motor3 = mot[2];
    assign motor4 = mot[3];
    assign brake1 = brake[0];
    assign brake2 = brake[1];
    assign brake3 = brake[2];
    assign brake4 = brake[3];

endmodule
